// File: rtl/logic_unit_seq.sv
// ----------------------------------------------------------------------------
// logic_unit_seq
//
// Sequential bitwise logic unit (AND / OR / XOR / NOR). A WIDTH-bit operand
// pair is captured on an input handshake and then processed LANE bits per
// cycle, lowest lane first. The registered result is presented with
// out_valid and held until the consumer takes it.
//
// Parameters:
//   WIDTH  operand/result width, multiple of LANE      (default 32)
//   LANE   bits processed per cycle                    (default 8)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair valid
//   in_ready   unit can accept an operand pair (high only in IDLE)
//   a, b       operands, sampled only at the accept edge
//   op         00 AND, 01 OR, 10 XOR, 11 NOR
//   out_valid  result valid (high only in DONE)
//   out_ready  consumer accepts the result
//   result     registered result
//   zero       result == 0, built only with LOGIC_UNIT_ZERO_FLAG_EN defined;
//              tied to 0 otherwise
//
// Build option:
//   LOGIC_UNIT_ZERO_FLAG_EN  adds the registered zero flag
// ----------------------------------------------------------------------------
module logic_unit_seq #(
    parameter int WIDTH = 32,
    parameter int LANE  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int N     = WIDTH / LANE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       op_q;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] result_q;

    logic [LANE-1:0]  lane_a;
    logic [LANE-1:0]  lane_b;
    logic [LANE-1:0]  lane_res;
    logic             accept;

    function automatic logic [LANE-1:0] lane_op(
        input logic [LANE-1:0] x,
        input logic [LANE-1:0] y,
        input logic [1:0]      sel
    );
        logic [LANE-1:0] r;
        case (sel)
            2'b00:   r = x & y;
            2'b01:   r = x | y;
            2'b10:   r = x ^ y;
            default: r = ~(x | y);
        endcase
        return r;
    endfunction

    assign accept = in_valid && (state == IDLE);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid)          state_nxt = BUSY;
            BUSY: if (cnt == CNT_LAST)   state_nxt = DONE;
            DONE: if (out_ready)         state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs decoded straight from the state register, so there is
    // no combinational path from any input to in_ready / out_valid.
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Lane select and operation on the captured operands
    // ------------------------------------------------------------------
    always_comb begin
        lane_a = '0;
        lane_b = '0;
        for (int i = 0; i < N; i++) begin
            if (cnt == CNT_W'(i)) begin
                lane_a = a_q[i*LANE +: LANE];
                lane_b = b_q[i*LANE +: LANE];
            end
        end
        lane_res = lane_op(lane_a, lane_b, op_q);
    end

    // ------------------------------------------------------------------
    // Operand capture, lane counter and result register.
    // Lanes not yet written keep the previous operation's value; the
    // counter saturates at the last lane instead of wrapping.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cnt      <= '0;
            result_q <= '0;
        end else if (accept) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= op;
            cnt  <= '0;
        end else if (state == BUSY) begin
            for (int i = 0; i < N; i++) begin
                if (cnt == CNT_W'(i)) begin
                    result_q[i*LANE +: LANE] <= lane_res;
                end
            end
            if (cnt != CNT_LAST) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign result = result_q;

`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    // Set at accept, knocked down by the first nonzero lane written.
    logic zero_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
        end else if (accept) begin
            zero_q <= 1'b1;
        end else if ((state == BUSY) && (lane_res != '0)) begin
            zero_q <= 1'b0;
        end
    end

    assign zero = zero_q;
`else
    assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_logic_unit_seq.sv
module tb_logic_unit_seq;

    localparam int W  = 32;
    localparam int L  = 8;
    localparam int NL = W / L;

    logic          clk;
    logic          rst_n;

    // multi-lane instance
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [1:0]    op;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          zero;

    // single-lane instance
    logic          in_valid1;
    logic          in_ready1;
    logic [W-1:0]  a1;
    logic [W-1:0]  b1;
    logic [1:0]    op1;
    logic          out_valid1;
    logic          out_ready1;
    logic [W-1:0]  result1;
    logic          zero1;

    int n_tests;
    int n_fail;

    logic [W-1:0] last_result;

    logic zflag_built;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   op;
        logic [W-1:0] exp;
        int           hold;
        string        name;
    } vec_t;

    vec_t vecs[6];

    logic_unit_seq #(.WIDTH(W), .LANE(L)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    logic_unit_seq #(.WIDTH(W), .LANE(W)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .op        (op1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .result    (result1),
        .zero      (zero1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Whole-word reference: the operation applies bitwise to all WIDTH bits.
    function automatic logic [W-1:0] ref_op(input logic [W-1:0] x,
                                            input logic [W-1:0] y,
                                            input logic [1:0]   s);
        case (s)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x ^ y;
            default: return ~(x | y);
        endcase
    endfunction

    function automatic logic ref_zero(input logic [W-1:0] r);
        return zflag_built ? (r == '0) : 1'b0;
    endfunction

    task automatic check32(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check1(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for in_ready, accept one operand pair, keep in_valid high with
    // junk operands while busy, measure latency, check the result, apply
    // 'hold' cycles of backpressure, then complete the output handshake.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_b,
                          input logic [1:0] top, input logic [W-1:0] exp,
                          input int hold, input string nm);
        int cyc;
        logic [W-1:0] held;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            tick();
            cyc++;
        end
        check1({nm, " in_ready before accept"}, in_ready, 1'b1);
        a        = ta;
        b        = tb_b;
        op       = top;
        in_valid = 1'b1;
        tick();
        a  = $urandom;
        b  = $urandom;
        op = 2'($urandom_range(0, 3));
        check1({nm, " in_ready after accept"}, in_ready, 1'b0);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        check32({nm, " latency"}, cyc, NL);
        check32({nm, " result"}, result, exp);
        check1({nm, " zero"}, zero, ref_zero(exp));
        check1({nm, " in_ready in DONE"}, in_ready, 1'b0);
        held = result;
        for (int i = 0; i < hold; i++) begin
            tick();
            check1({nm, " out_valid held"}, out_valid, 1'b1);
            check32({nm, " result held"}, result, held);
            check1({nm, " in_ready held low"}, in_ready, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check1({nm, " out_valid after handshake"}, out_valid, 1'b0);
        check1({nm, " in_ready after handshake"}, in_ready, 1'b1);
        last_result = exp;
    endtask

    initial begin
        int cyc;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [1:0]   rop;

        n_tests = 0;
        n_fail  = 0;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
        zflag_built = 1'b1;
`else
        zflag_built = 1'b0;
`endif
        last_result = '0;

        vecs[0] = '{32'hF0F0_1234, 32'hFF00_FFFF, 2'b00, 32'hF000_1234, 0, "and"};
        vecs[1] = '{32'h0000_00FF, 32'h0F00_0000, 2'b01, 32'h0F00_00FF, 0, "or"};
        vecs[2] = '{32'h0000_0000, 32'h0000_0000, 2'b11, 32'hFFFF_FFFF, 0, "nor"};
        vecs[3] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b10, 32'h0000_0000, 0, "xor_zero"};
        vecs[4] = '{32'h1234_5678, 32'h0F0F_F0F0, 2'b10, 32'h1D3B_A688, 5, "backpressure"};
        vecs[5] = '{32'hAAAA_0000, 32'h5555_0001, 2'b00, 32'h0000_0000, 0, "back_to_back"};

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        a          = '0;
        b          = '0;
        op         = '0;
        in_valid1  = 1'b0;
        out_ready1 = 1'b0;
        a1         = '0;
        b1         = '0;
        op1        = '0;

        // Reset state
        #12;
        check1("reset out_valid", out_valid, 1'b0);
        check32("reset result", result, '0);
        check1("reset zero", zero, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check1("post-reset in_ready", in_ready, 1'b1);
        check1("post-reset out_valid", out_valid, 1'b0);

        // Directed vectors
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp,
                   vecs[i].hold, vecs[i].name);
        end

        // Mid-operation reset: lanes 0..1 written, upper lanes still old
        run_op(32'hFFFF_FFFF, 32'h0000_0000, 2'b01, 32'hFFFF_FFFF, 0, "pre_reset");
        a        = 32'h0000_0000;
        b        = 32'h0000_0000;
        op       = 2'b00;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check32("partial lanes low", {16'h0, result[15:0]}, 32'h0);
        check32("partial lanes high", {result[31:16], 16'h0}, 32'hFFFF_0000);
        rst_n = 1'b0;
        #1;
        check1("reset busy out_valid", out_valid, 1'b0);
        check32("reset busy result", result, '0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check1("reset busy in_ready", in_ready, 1'b1);
        run_op(32'h8000_0001, 32'h0000_0100, 2'b01, 32'h8000_0101, 0, "after_reset");

        // Reset while in DONE with the result waiting
        a        = 32'h1111_1111;
        b        = 32'h2222_2222;
        op       = 2'b01;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check32("done result", result, 32'h3333_3333);
        rst_n = 1'b0;
        #1;
        check1("reset done out_valid", out_valid, 1'b0);
        check32("reset done result", result, '0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check1("reset done in_ready", in_ready, 1'b1);

        // Single-lane instance
        a1        = 32'hA5A5_A5A5;
        b1        = 32'hA5A5_A5A5;
        op1       = 2'b00;
        in_valid1 = 1'b1;
        check1("single in_ready", in_ready1, 1'b1);
        tick();
        in_valid1 = 1'b0;
        a1        = 32'h0;
        check1("single busy out_valid", out_valid1, 1'b0);
        tick();
        check1("single out_valid", out_valid1, 1'b1);
        check32("single result", result1, 32'hA5A5_A5A5);
        check1("single zero", zero1, ref_zero(32'hA5A5_A5A5));
        out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;
        check1("single handshake out_valid", out_valid1, 1'b0);
        check1("single handshake in_ready", in_ready1, 1'b1);

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
            rop = 2'($urandom_range(0, 3));
            run_op(ra, rb, rop, ref_op(ra, rb, rop), int'($urandom_range(0, 2)), "random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
